// File: rtl/mc_control_fsm.sv
// Main control sequencer of the multicycle MIPS datapath.
// Moore FSM: datapath selects/enables are registered alongside the state they belong to.
module mc_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       irwrite,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       regwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBeq    = 4'd8,
      StAddiEx = 4'd9,
      StAddiWb = 4'd10,
      StJump   = 4'd11,
      StBadOp  = 4'd12
   } state_e;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       illegal;
   } ctrl_t;

   state_e state_q, state_d;
   ctrl_t  ctrl_q;

   // Control word for a given state; unlisted fields and unreachable encodings are all-zero.
   function automatic ctrl_t decode(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         StDecode: c.alusrcb = 2'b11;
         StMemAdr: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         StMemRd: c.iord = 1'b1;
         StMemWb: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         StMemWr: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         StExec: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b10;
         end
         StAluWb: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         StBeq: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.branch  = 1'b1;
            c.pcsrc   = 2'b01;
         end
         StAddiEx: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         StAddiWb: c.regwrite = 1'b1;
         StJump: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = 2'b10;
         end
         StBadOp: c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            if (op == OP_LW || op == OP_SW) state_d = StMemAdr;
            else if (op == OP_RTYPE)        state_d = StExec;
            else if (op == OP_BEQ)          state_d = StBeq;
            else if (op == OP_ADDI)         state_d = StAddiEx;
            else if (op == OP_J)            state_d = StJump;
            else                            state_d = StBadOp;
         end
         StMemAdr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
         StMemRd:  state_d = StMemWb;
         StExec:   state_d = StAluWb;
         StAddiEx: state_d = StAddiWb;
         default:  state_d = StFetch;
      endcase
   end

   // Control word is preloaded with FETCH values so the first cycle after release is correct.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         ctrl_q  <= decode(StFetch);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
      end
   end

   // Reset masks every control output immediately, independent of the clock.
   assign irwrite  = rst_n & ctrl_q.irwrite;
   assign pcen     = rst_n & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
   assign iord     = rst_n & ctrl_q.iord;
   assign memwrite = rst_n & ctrl_q.memwrite;
   assign regwrite = rst_n & ctrl_q.regwrite;
   assign memtoreg = rst_n & ctrl_q.memtoreg;
   assign regdst   = rst_n & ctrl_q.regdst;
   assign alusrca  = rst_n & ctrl_q.alusrca;
   assign alusrcb  = {2{rst_n}} & ctrl_q.alusrcb;
   assign aluop    = {2{rst_n}} & ctrl_q.aluop;
   assign pcsrc    = {2{rst_n}} & ctrl_q.pcsrc;
   assign illegal  = rst_n & ctrl_q.illegal;
   assign state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle.
module tb_mc_control_fsm;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       irwrite, pcen, iord, memwrite, regwrite, memtoreg, regdst, alusrca, illegal;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;

   int compared = 0;
   int mismatched = 0;

   mc_control_fsm dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .zero     (zero),
      .irwrite  (irwrite),
      .pcen     (pcen),
      .iord     (iord),
      .memwrite (memwrite),
      .regwrite (regwrite),
      .memtoreg (memtoreg),
      .regdst   (regdst),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .pcsrc    (pcsrc),
      .state    (state),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field order: irwrite pcen iord memwrite | regwrite memtoreg regdst alusrca | alusrcb | aluop
   //              | pcsrc | illegal
   localparam logic [14:0] O_ZERO   = 15'b0000_0000_00_00_00_0;
   localparam logic [14:0] O_FETCH  = 15'b1100_0000_01_00_00_0;
   localparam logic [14:0] O_DECODE = 15'b0000_0000_11_00_00_0;
   localparam logic [14:0] O_MEMADR = 15'b0000_0001_10_00_00_0;
   localparam logic [14:0] O_MEMRD  = 15'b0010_0000_00_00_00_0;
   localparam logic [14:0] O_MEMWB  = 15'b0000_1100_00_00_00_0;
   localparam logic [14:0] O_MEMWR  = 15'b0011_0000_00_00_00_0;
   localparam logic [14:0] O_EXEC   = 15'b0000_0001_00_10_00_0;
   localparam logic [14:0] O_ALUWB  = 15'b0000_1010_00_00_00_0;
   localparam logic [14:0] O_BEQ_T  = 15'b0100_0001_00_01_01_0;
   localparam logic [14:0] O_BEQ_NT = 15'b0000_0001_00_01_01_0;
   localparam logic [14:0] O_ADDIEX = 15'b0000_0001_10_00_00_0;
   localparam logic [14:0] O_ADDIWB = 15'b0000_1000_00_00_00_0;
   localparam logic [14:0] O_JUMP   = 15'b0100_0000_00_00_10_0;
   localparam logic [14:0] O_BADOP  = 15'b0000_0000_00_00_00_1;

   task automatic chk_now(input string tag, input logic [3:0] exp_state,
                          input logic [14:0] exp_out);
      logic [18:0] obs;
      logic [18:0] exp;
      obs = {state, irwrite, pcen, iord, memwrite, regwrite, memtoreg, regdst, alusrca,
             alusrcb, aluop, pcsrc, illegal};
      exp = {exp_state, exp_out};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed state=%0d out=%b, expected state=%0d out=%b",
                tag, obs[18:15], obs[14:0], exp[18:15], exp[14:0]);
      end
   endtask

   task automatic tick_chk(input string tag, input logic [3:0] exp_state,
                           input logic [14:0] exp_out);
      @(negedge clk);
      chk_now(tag, exp_state, exp_out);
   endtask

   initial begin
      rst_n = 1'b0;
      op    = 6'h23;
      zero  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_now("reset", 4'd0, O_ZERO);

      // LW: 0,1,2,3,4,0
      rst_n = 1'b1;
      #1 chk_now("lw_fetch", 4'd0, O_FETCH);
      tick_chk("lw_decode", 4'd1, O_DECODE);
      tick_chk("lw_memadr", 4'd2, O_MEMADR);
      tick_chk("lw_memrd", 4'd3, O_MEMRD);
      tick_chk("lw_memwb", 4'd4, O_MEMWB);
      tick_chk("lw_done", 4'd0, O_FETCH);

      // SW: 0,1,2,5,0
      op = 6'h2B;
      tick_chk("sw_decode", 4'd1, O_DECODE);
      tick_chk("sw_memadr", 4'd2, O_MEMADR);
      tick_chk("sw_memwr", 4'd5, O_MEMWR);
      tick_chk("sw_done", 4'd0, O_FETCH);

      // BEQ taken; ZERO high in FETCH/DECODE must not add a PC write
      op   = 6'h04;
      zero = 1'b1;
      #1 chk_now("beq_fetch_z1", 4'd0, O_FETCH);
      tick_chk("beq_decode_z1", 4'd1, O_DECODE);
      tick_chk("beq_taken", 4'd8, O_BEQ_T);
      zero = 1'b0;
      #1 chk_now("beq_zero_drop", 4'd8, O_BEQ_NT);
      tick_chk("beq_done", 4'd0, O_FETCH);

      // BEQ not taken
      tick_chk("beqnt_decode", 4'd1, O_DECODE);
      tick_chk("beq_not_taken", 4'd8, O_BEQ_NT);
      tick_chk("beqnt_done", 4'd0, O_FETCH);

      // R-type then ADDI back-to-back
      op = 6'h00;
      tick_chk("r_decode", 4'd1, O_DECODE);
      tick_chk("r_exec", 4'd6, O_EXEC);
      tick_chk("r_aluwb", 4'd7, O_ALUWB);
      tick_chk("r_done", 4'd0, O_FETCH);
      op = 6'h08;
      tick_chk("addi_decode", 4'd1, O_DECODE);
      tick_chk("addi_ex", 4'd9, O_ADDIEX);
      tick_chk("addi_wb", 4'd10, O_ADDIWB);
      tick_chk("addi_done", 4'd0, O_FETCH);

      // J
      op = 6'h02;
      tick_chk("j_decode", 4'd1, O_DECODE);
      tick_chk("j_jump", 4'd11, O_JUMP);
      tick_chk("j_done", 4'd0, O_FETCH);

      // Illegal opcode: 0,1,12,0 with a single ILLEGAL pulse
      op = 6'h3F;
      tick_chk("bad_decode", 4'd1, O_DECODE);
      tick_chk("bad_badop", 4'd12, O_BADOP);
      tick_chk("bad_done", 4'd0, O_FETCH);

      // SW aborted by reset while in MEMWR
      op = 6'h2B;
      tick_chk("abort_decode", 4'd1, O_DECODE);
      tick_chk("abort_memadr", 4'd2, O_MEMADR);
      tick_chk("abort_memwr", 4'd5, O_MEMWR);
      #2 rst_n = 1'b0;
      #1 chk_now("abort_async", 4'd0, O_ZERO);
      @(posedge clk);
      @(negedge clk);
      chk_now("abort_held", 4'd0, O_ZERO);
      op    = 6'h00;
      rst_n = 1'b1;
      #1 chk_now("abort_fetch", 4'd0, O_FETCH);
      tick_chk("post_decode", 4'd1, O_DECODE);
      tick_chk("post_exec", 4'd6, O_EXEC);
      tick_chk("post_aluwb", 4'd7, O_ALUWB);
      tick_chk("post_done", 4'd0, O_FETCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
